// File: rtl/ws2801_receiver_if.sv
// ws2801_receiver_if: line-side and pixel-side signals of the WS2801 receiver.
//   master : drives the serial line (dIn, clkIn) and consumes the pixel stream
//   slave  : the receiver; samples the line, produces pixels and frame status
//   dIn/clkIn        serial data/clock, asynchronous to the receiver clock
//   pixel_rgb/idx    last complete pixel and its index, pixel_valid strobe
//   frame_done       strobe at latch timeout, pixel_count/frame_overflow status
//   busy             frame reception in progress
interface ws2801_receiver_if #(
    parameter int LEDS = 50,
    parameter int IW   = $clog2(LEDS + 1)
);
    logic          dIn;
    logic          clkIn;
    logic [23:0]   pixel_rgb;
    logic [IW-1:0] pixel_idx;
    logic          pixel_valid;
    logic          frame_done;
    logic [IW-1:0] pixel_count;
    logic          frame_overflow;
    logic          busy;

    modport master (
        output dIn, clkIn,
        input  pixel_rgb, pixel_idx, pixel_valid, frame_done,
               pixel_count, frame_overflow, busy
    );

    modport slave (
        input  dIn, clkIn,
        output pixel_rgb, pixel_idx, pixel_valid, frame_done,
               pixel_count, frame_overflow, busy
    );
endinterface

// File: rtl/ws2801_receiver.sv
// ws2801_receiver: deserialises a WS2801 serial clock/data stream into 24-bit
// pixels, tagging each with its frame index, and ends a frame when the serial
// clock shows no rising edge for the latch time.
//   clk    system clock (>= 4x serial clock rate)
//   rst    synchronous reset, active-high
//   bus    ws2801_receiver_if.slave: dIn/clkIn in; pixel_rgb, pixel_idx,
//          pixel_valid, frame_done, pixel_count, frame_overflow, busy out
module ws2801_receiver #(
    parameter int LEDS     = 50,
    parameter int CLK_HZ   = 50_000_000,
    parameter int LATCH_US = 500
) (
    input  logic              clk,
    input  logic              rst,
    ws2801_receiver_if.slave  bus
);
    localparam int LATCH_CYC = (CLK_HZ / 1_000_000) * LATCH_US;
    localparam int IW        = $clog2(LEDS + 1);
    localparam int TW        = $clog2(LATCH_CYC + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, LATCH} state_e;

    state_e        state_q, state_d;
    logic          din_s1_q, din_s2_q;
    logic          ck_s1_q, ck_s2_q, ck_s3_q;
    logic [23:0]   shift_q, shift_d;
    logic [4:0]    bit_cnt_q, bit_cnt_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [IW-1:0] pix_cnt_q;
    logic          cmp_q, cmp_d;     // pixel completed last cycle
    logic          start;            // IDLE -> SHIFT this cycle
    logic          rise;

    logic [23:0]   rgb_q;
    logic [IW-1:0] idx_q, count_q;
    logic          valid_q, done_q, ovf_q;

    assign rise = ck_s2_q & ~ck_s3_q;

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        timer_d   = timer_q;
        cmp_d     = 1'b0;
        start     = 1'b0;
        case (state_q)
            IDLE: begin
                if (rise) begin
                    state_d   = SHIFT;
                    shift_d   = {shift_q[22:0], din_s2_q};
                    bit_cnt_d = 5'd1;
                    timer_d   = '0;
                    start     = 1'b1;
                end
            end
            SHIFT: begin
                // a rise in the expiry cycle keeps the frame alive
                if (rise) begin
                    shift_d = {shift_q[22:0], din_s2_q};
                    timer_d = '0;
                    if (bit_cnt_q == 5'd23) begin
                        bit_cnt_d = '0;
                        cmp_d     = 1'b1;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 5'd1;
                    end
                end else if (timer_q == TW'(LATCH_CYC - 1)) begin
                    state_d = LATCH;
                end else if (timer_q != TW'(LATCH_CYC)) begin
                    timer_d = timer_q + 1'b1;
                end
            end
            LATCH: begin
                state_d   = IDLE;
                bit_cnt_d = '0;
                timer_d   = '0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            din_s1_q  <= 1'b0;
            din_s2_q  <= 1'b0;
            ck_s1_q   <= 1'b0;
            ck_s2_q   <= 1'b0;
            ck_s3_q   <= 1'b0;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            timer_q   <= '0;
            pix_cnt_q <= '0;
            cmp_q     <= 1'b0;
            rgb_q     <= '0;
            idx_q     <= '0;
            count_q   <= '0;
            valid_q   <= 1'b0;
            done_q    <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            din_s1_q  <= bus.dIn;
            din_s2_q  <= din_s1_q;
            ck_s1_q   <= bus.clkIn;
            ck_s2_q   <= ck_s1_q;
            ck_s3_q   <= ck_s2_q;
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            timer_q   <= timer_d;
            cmp_q     <= cmp_d;
            valid_q   <= 1'b0;
            // registered on entry to LATCH so the strobe and count line up
            done_q    <= (state_q == SHIFT) && (state_d == LATCH);
            if ((state_q == SHIFT) && (state_d == LATCH))
                count_q <= pix_cnt_q;
            if (start) begin
                pix_cnt_q <= '0;
                ovf_q     <= 1'b0;
            end else if (cmp_q) begin
                // shift_q is stable here: the next rise is >= 4 cycles away
                if (pix_cnt_q < IW'(LEDS)) begin
                    valid_q   <= 1'b1;
                    rgb_q     <= shift_q;
                    idx_q     <= pix_cnt_q;
                    pix_cnt_q <= pix_cnt_q + 1'b1;
                end else begin
                    ovf_q     <= 1'b1;
                end
            end
        end
    end

    assign bus.pixel_rgb      = rgb_q;
    assign bus.pixel_idx      = idx_q;
    assign bus.pixel_valid    = valid_q;
    assign bus.frame_done     = done_q;
    assign bus.pixel_count    = count_q;
    assign bus.frame_overflow = ovf_q;
    assign bus.busy           = (state_q == SHIFT);
endmodule

// File: tb/tb_ws2801_receiver.sv
// Scoreboard bench for ws2801_receiver: stimulus tasks push expected pixels
// and frame results as bits go out; a monitor pops and compares on strobes.
module tb_ws2801_receiver;
    localparam int LEDS      = 50;
    localparam int CLK_HZ    = 2_000_000;
    localparam int LATCH_US  = 40;
    localparam int LATCH_CYC = (CLK_HZ / 1_000_000) * LATCH_US;
    localparam int IW        = $clog2(LEDS + 1);

    typedef struct {
        logic [23:0] rgb;
        int          idx;
        longint      t;
    } px_t;
    typedef struct {
        int cnt;
        bit ovf;
    } fr_t;

    logic   clk = 1'b0;
    logic   rst = 1'b1;
    int     total = 0;
    int     bad = 0;
    longint cyc = 0;

    px_t    exp_px[$];
    fr_t    exp_fr[$];
    px_t    pe;
    fr_t    fe;

    // reference model: bit stream of the frame in flight
    int          nbits = 0;
    logic [23:0] cur = '0;
    int          last_cnt = 0;
    bit          last_ovf = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ws2801_receiver_if #(.LEDS(LEDS)) bus ();

    ws2801_receiver #(.LEDS(LEDS), .CLK_HZ(CLK_HZ), .LATCH_US(LATCH_US)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s act=%h exp=%h", nm, a, e);
        end
    endtask

    // one serial bit: data set with clock low for lo cycles, then clock high hi cycles
    task automatic send_bit(input logic b, input int lo, input int hi);
        bus.clkIn = 1'b0;
        bus.dIn   = b;
        repeat (lo) @(negedge clk);
        cur = {cur[22:0], b};
        nbits++;
        if (nbits % 24 == 0 && nbits / 24 - 1 < LEDS)
            exp_px.push_back('{rgb: cur, idx: nbits / 24 - 1, t: cyc + 4});
        bus.clkIn = 1'b1;
        repeat (hi) @(negedge clk);
    endtask

    task automatic send_word(input logic [23:0] v, input int n, input int lo, input int hi);
        for (int i = 0; i < n; i++) send_bit(v[23 - i], lo, hi);
    endtask

    task automatic end_frame();
        int np;
        bus.clkIn = 1'b0;
        np = nbits / 24;
        if (nbits > 0) begin
            last_cnt = (np > LEDS) ? LEDS : np;
            last_ovf = (np > LEDS);
            exp_fr.push_back('{cnt: last_cnt, ovf: last_ovf});
        end
        nbits = 0;
        repeat (LATCH_CYC + 10) @(negedge clk);
    endtask

    function automatic logic [63:0] outs();
        return 64'({bus.pixel_rgb, bus.pixel_idx, bus.pixel_valid, bus.frame_done,
                    bus.pixel_count, bus.frame_overflow, bus.busy});
    endfunction

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.pixel_valid || bus.frame_done) begin
                total++;
                if (bus.pixel_valid && bus.frame_done) begin
                    bad++;
                    $display("FAIL strobe_excl valid=1 done=1 exp=exclusive");
                end
            end
            if (bus.pixel_valid) begin
                total++;
                if (exp_px.size() == 0) begin
                    bad++;
                    $display("FAIL px_unexpected rgb=%h idx=%0d", bus.pixel_rgb, bus.pixel_idx);
                end else begin
                    pe = exp_px.pop_front();
                    if (bus.pixel_rgb !== pe.rgb || bus.pixel_idx !== IW'(pe.idx)) begin
                        bad++;
                        $display("FAIL px_data rgb=%h idx=%0d exp rgb=%h idx=%0d",
                                 bus.pixel_rgb, bus.pixel_idx, pe.rgb, pe.idx);
                    end
                    total++;
                    if (cyc != pe.t) begin
                        bad++;
                        $display("FAIL px_latency cyc=%0d exp=%0d", cyc, pe.t);
                    end
                end
            end
            if (bus.frame_done) begin
                total++;
                if (exp_fr.size() == 0) begin
                    bad++;
                    $display("FAIL fr_unexpected count=%0d", bus.pixel_count);
                end else begin
                    fe = exp_fr.pop_front();
                    if (bus.pixel_count !== IW'(fe.cnt) || bus.frame_overflow !== fe.ovf) begin
                        bad++;
                        $display("FAIL fr_status count=%0d ovf=%0b exp count=%0d ovf=%0b",
                                 bus.pixel_count, bus.frame_overflow, fe.cnt, fe.ovf);
                    end
                end
            end
        end
    end

    initial begin
        logic [23:0] v;
        int          np;
        bus.dIn   = 1'b0;
        bus.clkIn = 1'b0;
        rst       = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // idle after reset: everything quiet
        repeat (5) begin
            @(negedge clk);
            chk("reset_outs", outs(), 64'd0);
        end

        // single pixel
        send_word(24'hFF8001, 24, 4, 4);
        end_frame();
        chk("one_px_count", 64'(bus.pixel_count), 64'(last_cnt));

        // exactly LEDS pixels
        for (int i = 0; i < LEDS; i++) send_word(24'(i * 24'h010203), 24, 4, 4);
        end_frame();
        chk("full_count", 64'(bus.pixel_count), 64'(last_cnt));
        chk("full_ovf", 64'(bus.frame_overflow), 64'(last_ovf));

        // LEDS+2 pixels: the extra two are dropped
        for (int i = 0; i < LEDS + 2; i++) send_word(24'($urandom), 24, 4, 4);
        end_frame();
        chk("ovf_sticky", 64'(bus.frame_overflow), 64'(last_ovf));
        chk("ovf_count", 64'(bus.pixel_count), 64'(last_cnt));
        v = 24'($urandom);
        send_word(v, 1, 4, 4);
        chk("ovf_cleared", 64'(bus.frame_overflow), 64'd0);
        chk("busy_in_frame", 64'(bus.busy), 64'd1);
        send_word(v << 1, 23, 4, 4);
        end_frame();

        // one pixel plus a partial, then a clean frame
        send_word(24'hA5C33C, 24, 4, 4);
        send_word(24'h123456, 10, 4, 4);
        end_frame();
        chk("partial_count", 64'(bus.pixel_count), 64'(last_cnt));
        send_word(24'h0F0F0F, 24, 3, 3);
        end_frame();

        // long gaps at and just under the latch time keep the frame going
        v = 24'($urandom);
        for (int i = 0; i < 24; i++) begin
            if (i == 5)       send_bit(v[23 - i], LATCH_CYC - 5, 4);
            else if (i == 12) send_bit(v[23 - i], LATCH_CYC - 4, 4);
            else              send_bit(v[23 - i], 4, 4);
        end
        send_word(24'h00FF00, 24, 4, 4);
        end_frame();
        chk("gap_count", 64'(bus.pixel_count), 64'(last_cnt));

        // reset in the middle of a pixel discards the frame
        send_word(24'h445566, 24, 4, 4);
        send_word(24'hFFFFFF, 10, 4, 4);
        rst       = 1'b1;
        bus.clkIn = 1'b0;
        nbits     = 0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_outs", outs(), 64'd0);
        send_word(24'h7E57ED, 24, 4, 4);
        end_frame();

        // random frames with random serial phases
        for (int f = 0; f < 6; f++) begin
            np = $urandom_range(1, 4);
            for (int p = 0; p < np; p++)
                send_word(24'($urandom), 24, $urandom_range(2, 6), $urandom_range(2, 6));
            end_frame();
            chk("rand_count", 64'(bus.pixel_count), 64'(last_cnt));
        end

        repeat (20) @(negedge clk);
        chk("px_queue_empty", 64'(exp_px.size()), 64'd0);
        chk("fr_queue_empty", 64'(exp_fr.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
